// File: rtl/mbr_prefetch_unit_if.sv
// Bus bundle for the prefetch unit: fetch control, instruction-memory req/ack and consumer valid/ready.
// The unit connects through the slave modport; its environment uses master.
interface mbr_prefetch_unit_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               fetch;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_addr;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] instruction_in;
  logic               instr_valid;
  logic               instr_ready;
  logic [OPC_W-1:0]   instruction_out;
  logic [DATA_W-1:0]  data_out;
  logic [ADDR_W-1:0]  instr_addr;
  logic [CNT_W-1:0]   count;

  modport master (
    output fetch, pc_load, pc_load_addr, mem_ack, instruction_in, instr_ready,
    input  mem_req, mem_addr, instr_valid, instruction_out, data_out, instr_addr, count
  );

  modport slave (
    input  fetch, pc_load, pc_load_addr, mem_ack, instruction_in, instr_ready,
    output mem_req, mem_addr, instr_valid, instruction_out, data_out, instr_addr, count
  );
endinterface

// File: rtl/mbr_prefetch_unit.sv
// Memory buffer register with a first-word-fall-through instruction prefetch queue.
// Define MBRU_SIGN_EXT_EN to sign-extend the operand; by default it is zero-extended.
//
// state   | meaning
// IDLE    | no request outstanding
// WAIT    | request outstanding, response will be queued
// DISCARD | request outstanding after pc_load, response will be dropped
module mbr_prefetch_unit #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8
) (
  input logic clk,
  input logic rst,
  mbr_prefetch_unit_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OPND_W = INSTR_W - OPC_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [ADDR_W-1:0]  held_q, held_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  fifo_addr [DEPTH];
  logic [INSTR_W-1:0] fifo_word [DEPTH];
  logic               push, pop, flush;
  logic [INSTR_W-1:0] head_word;
  logic [OPND_W-1:0]  operand;
  logic [DATA_W-1:0]  operand_ext;
  logic               fill;
  logic               valid;

  assign valid = (cnt != '0);

  // pc_load overrides both queue ports so a flush never races a push or pop.
  always_comb begin
    flush   = bus.pc_load;
    pop     = valid && bus.instr_ready && !flush;
    push    = (state == WAIT) && bus.mem_ack && !flush;
    cnt_nxt = flush ? '0 : cnt + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    held_nxt  = held_q;
    case (state)
      IDLE: begin
        if (flush) begin
          addr_nxt = bus.pc_load_addr;
        end else if (bus.fetch && cnt < FULL) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          if (bus.mem_ack) begin
            state_nxt = IDLE;
            addr_nxt  = bus.pc_load_addr;
          end else begin
            state_nxt = DISCARD;
            held_nxt  = bus.pc_load_addr;
          end
        end else if (bus.mem_ack) begin
          addr_nxt  = addr_q + 1'b1;
          state_nxt = (bus.fetch && cnt_nxt < FULL) ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        // mem_addr keeps the old address until the orphaned response arrives.
        if (bus.mem_ack) begin
          state_nxt = IDLE;
          addr_nxt  = flush ? bus.pc_load_addr : held_q;
        end else if (flush) begin
          held_nxt = bus.pc_load_addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      held_q <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      held_q <= held_nxt;
      cnt    <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= addr_q;
      fifo_word[wr_ptr] <= bus.instruction_in;
    end
  end

  always_comb begin
    head_word = fifo_word[rd_ptr];
    operand   = head_word[OPND_W-1:0];
`ifdef MBRU_SIGN_EXT_EN
    fill = operand[OPND_W-1];
`else
    fill = 1'b0;
`endif
    operand_ext = {DATA_W{fill}};
    operand_ext[OPND_W-1:0] = operand;
  end

  assign bus.mem_req         = (state != IDLE);
  assign bus.mem_addr        = addr_q;
  assign bus.count           = cnt;
  assign bus.instr_valid     = valid;
  assign bus.instruction_out = valid ? head_word[INSTR_W-1 -: OPC_W] : '0;
  assign bus.data_out        = valid ? operand_ext : '0;
  assign bus.instr_addr      = valid ? fifo_addr[rd_ptr] : '0;
endmodule
